parity_check: RTL and testbench

//  Receive-side companion to the even-parity generator. Accepts a word and its

---
 rtl/parity_check_pkg.sv | 8 +
 rtl/parity_check_if.sv | 13 +
 rtl/parity_check_parity.sv | 7 +
 rtl/parity_check.sv | 121 ++++++++++++
 tb/tb_parity_check.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/parity_check_pkg.sv
// parity_check_pkg: shared state encoding for the parity checker skid buffer
package parity_check_pkg;
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_e;
endpackage

// File: rtl/parity_check_if.sv
// parity_check_if: valid/ready word+parity input stream and checked output stream
interface parity_check_if #(parameter int DATA_WIDTH = 8);
   logic [DATA_WIDTH-1:0] di;
   logic                  pi;
   logic                  di_valid;
   logic                  di_ready;
   logic [DATA_WIDTH-1:0] dout;
   logic                  do_err;
   logic                  do_valid;
   logic                  do_ready;
   modport master (output di, pi, di_valid, do_ready, input di_ready, dout, do_err, do_valid);
   modport slave  (input di, pi, di_valid, do_ready, output di_ready, dout, do_err, do_valid);
endinterface

// File: rtl/parity_check_parity.sv
// parity: even-parity generator, p is the XOR of all bits of d
module parity #(parameter int WIDTH = 9) (
   input  logic [WIDTH-1:0] d,
   output logic             p
);
   assign p = ^d;
endmodule

// File: rtl/parity_check.sv
// parity_check: recomputes received parity, forwards words through a 2-entry skid buffer, keeps error stats
module parity_check
   import parity_check_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ERR_CNT_WIDTH = 16,
   parameter bit ODD           = 1'b0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clr,
   parity_check_if.slave            bus,
   output logic                     err_sticky,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt,
   output logic [ERR_CNT_WIDTH-1:0] word_cnt,
   output logic                     err_ovf
);
   localparam logic [ERR_CNT_WIDTH-1:0] SAT = '1;
   state_e                   state_q, state_d;
   logic [DATA_WIDTH-1:0]    or_q, or_d, sr_q, sr_d;
   logic                     ore_q, ore_d, sre_q, sre_d;
   logic                     di_ready_q, di_ready_d;
   logic                     even, err, accept, emit;
   logic                     err_sticky_q, err_sticky_d, err_ovf_q, err_ovf_d;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d, word_cnt_q, word_cnt_d;
   logic [ERR_CNT_WIDTH-1:0] ec_base, wc_base;
   logic                     acc_err;

   parity #(.WIDTH(DATA_WIDTH + 1)) u_parity (.d({bus.di, bus.pi}), .p(even));

   assign err    = even ^ ODD;
   assign accept = bus.di_valid & di_ready_q;
   assign emit   = bus.do_valid & bus.do_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         or_q       <= '0;
         ore_q      <= 1'b0;
         sr_q       <= '0;
         sre_q      <= 1'b0;
         di_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         or_q       <= or_d;
         ore_q      <= ore_d;
         sr_q       <= sr_d;
         sre_q      <= sre_d;
         di_ready_q <= di_ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      or_d    = or_q;
      ore_d   = ore_q;
      sr_d    = sr_q;
      sre_d   = sre_q;
      case (state_q)
         ST_EMPTY: if (accept) begin
            or_d    = bus.di;
            ore_d   = err;
            state_d = ST_BUSY;
         end
         ST_BUSY: if (accept && emit) begin
            or_d  = bus.di;
            ore_d = err;
         end else if (accept) begin
            sr_d    = bus.di;
            sre_d   = err;
            state_d = ST_FULL;
         end else if (emit) begin
            state_d = ST_EMPTY;
         end
         ST_FULL: if (emit) begin
            or_d    = sr_q;
            ore_d   = sre_q;
            state_d = ST_BUSY;
         end
         default: state_d = ST_EMPTY;
      endcase
      di_ready_d = state_d != ST_FULL;
   end

   always_comb begin
      bus.do_valid = state_q != ST_EMPTY;
      bus.dout     = or_q;
      bus.do_err   = ore_q;
      bus.di_ready = di_ready_q;
   end

   // clear takes effect first so a same-cycle accept is counted into the fresh stats
   always_comb begin
      acc_err      = accept & err;
      ec_base      = clr ? '0 : err_cnt_q;
      wc_base      = clr ? '0 : word_cnt_q;
      word_cnt_d   = (accept && wc_base != SAT) ? wc_base + 1'b1 : wc_base;
      err_cnt_d    = (acc_err && ec_base != SAT) ? ec_base + 1'b1 : ec_base;
      err_ovf_d    = (!clr & err_ovf_q) | (acc_err & (ec_base == SAT));
      err_sticky_d = (!clr & err_sticky_q) | acc_err;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sticky_q <= 1'b0;
         err_ovf_q    <= 1'b0;
         err_cnt_q    <= '0;
         word_cnt_q   <= '0;
      end else begin
         err_sticky_q <= err_sticky_d;
         err_ovf_q    <= err_ovf_d;
         err_cnt_q    <= err_cnt_d;
         word_cnt_q   <= word_cnt_d;
      end
   end

   assign err_sticky = err_sticky_q;
   assign err_ovf    = err_ovf_q;
   assign err_cnt    = err_cnt_q;
   assign word_cnt   = word_cnt_q;
endmodule

// File: tb/tb_parity_check.sv
// tb_parity_check: table vectors, corner sequences and randomized traffic against a queue-based model
module tb_parity_check;
   localparam int MAX = 65535;
   logic clk = 1'b0, rst = 1'b1, clr = 1'b0, clr2 = 1'b0;
   logic sticky, ovf, sticky2, ovf2;
   logic [15:0] ecnt, wcnt;
   logic [1:0]  ecnt2, wcnt2;
   int total = 0, bad = 0;

   typedef struct {logic [7:0] d; logic e;} ent_t;
   typedef struct {logic [7:0] d; logic p; logic e;} vec_t;
   ent_t q[$];
   logic [7:0] seen[$];
   int wc = 0, ec = 0;
   logic m_sticky = 1'b0, m_ovf = 1'b0;

   parity_check_if #(.DATA_WIDTH(8)) a ();
   parity_check_if #(.DATA_WIDTH(8)) b ();

   parity_check #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(16), .ODD(1'b0)) dut (
      .clk(clk), .rst(rst), .clr(clr), .bus(a),
      .err_sticky(sticky), .err_cnt(ecnt), .word_cnt(wcnt), .err_ovf(ovf));

   parity_check #(.DATA_WIDTH(8), .ERR_CNT_WIDTH(2), .ODD(1'b0)) dut2 (
      .clk(clk), .rst(rst), .clr(clr2), .bus(b),
      .err_sticky(sticky2), .err_cnt(ecnt2), .word_cnt(wcnt2), .err_ovf(ovf2));

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      wc = 0; ec = 0; m_sticky = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic cycle();
      logic acc, emt, cl, p, e;
      logic [7:0] d, od;
      acc = a.di_valid & a.di_ready;
      emt = a.do_valid & a.do_ready;
      cl = clr; d = a.di; p = a.pi; od = a.dout;
      e = 1'($countones({d, p}) % 2);
      @(posedge clk);
      #1;
      if (emt) begin
         seen.push_back(od);
         if (q.size() != 0) void'(q.pop_front());
      end
      if (cl) begin
         wc = 0; ec = 0; m_sticky = 1'b0; m_ovf = 1'b0;
      end
      if (acc) begin
         q.push_back('{d: d, e: e});
         if (wc < MAX) wc++;
         if (e) begin
            m_sticky = 1'b1;
            if (ec == MAX) m_ovf = 1'b1;
            else ec++;
         end
      end
      chk("do_valid", 32'(a.do_valid), 32'(q.size() != 0));
      chk("di_ready", 32'(a.di_ready), 32'(q.size() < 2));
      if (q.size() != 0) begin
         chk("do", 32'(a.dout), 32'(q[0].d));
         chk("do_err", 32'(a.do_err), 32'(q[0].e));
      end
      chk("word_cnt", 32'(wcnt), 32'(wc));
      chk("err_cnt", 32'(ecnt), 32'(ec));
      chk("err_sticky", 32'(sticky), 32'(m_sticky));
      chk("err_ovf", 32'(ovf), 32'(m_ovf));
   endtask

   task automatic idle(input int n);
      a.di_valid = 1'b0; a.do_ready = 1'b1; clr = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      vec_t tab[8];
      logic [7:0] exp3[3];
      tab[0] = '{8'hA5, 1'b0, 1'b0};
      tab[1] = '{8'h01, 1'b0, 1'b1};
      tab[2] = '{8'h01, 1'b1, 1'b0};
      tab[3] = '{8'hFF, 1'b0, 1'b0};
      tab[4] = '{8'hFF, 1'b1, 1'b1};
      tab[5] = '{8'h80, 1'b1, 1'b0};
      tab[6] = '{8'h7F, 1'b0, 1'b1};
      tab[7] = '{8'h00, 1'b1, 1'b1};
      exp3[0] = 8'h10; exp3[1] = 8'h11; exp3[2] = 8'h12;
      a.di = '0; a.pi = 1'b0; a.di_valid = 1'b0; a.do_ready = 1'b0;
      b.di = '0; b.pi = 1'b0; b.di_valid = 1'b0; b.do_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_di_ready", 32'(a.di_ready), 32'd1);
      chk("rst_do_valid", 32'(a.do_valid), 32'd0);
      chk("rst_do", 32'(a.dout), 32'd0);
      chk("rst_stats", 32'({sticky, ovf, ecnt, wcnt}), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         a.di = tab[i].d; a.pi = tab[i].p; a.di_valid = 1'b1; a.do_ready = 1'b1;
         cycle();
         chk("tab_do", 32'(a.dout), 32'(tab[i].d));
         chk("tab_do_err", 32'(a.do_err), 32'(tab[i].e));
         if (i == 0) chk("t1_cnts", 32'({wcnt, ecnt}), {16'd1, 16'd0});
         if (tab[i].e) chk("tab_sticky", 32'(sticky), 32'd1);
      end
      idle(3);

      seen.delete();
      a.do_ready = 1'b0; a.di_valid = 1'b1; a.pi = 1'b1;
      a.di = 8'h10; cycle();
      a.di = 8'h11; cycle();
      chk("t3_ready_low", 32'(a.di_ready), 32'd0);
      a.di = 8'h12; cycle();
      a.do_ready = 1'b1;
      for (int n = 0; n < 20 && seen.size() < 3; n++) begin
         logic took;
         took = a.di_valid & a.di_ready;
         cycle();
         if (took) a.di_valid = 1'b0;
      end
      chk("t3_count", 32'(seen.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         if (i < seen.size()) chk("t3_order", 32'(seen[i]), 32'(exp3[i]));
      idle(2);

      clr = 1'b1; a.di = 8'h01; a.pi = 1'b0; a.di_valid = 1'b1;
      cycle();
      clr = 1'b0; a.di_valid = 1'b0;
      chk("t5_clr_acc", 32'({sticky, ecnt, wcnt}), {15'd0, 1'b1, 16'd1, 16'd1});
      idle(2);

      b.do_ready = 1'b1; b.di_valid = 1'b1; b.di = 8'h01; b.pi = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("t4_at_sat", 32'({ovf2, ecnt2, wcnt2}), 32'b0_11_11);
      repeat (2) @(posedge clk);
      #1;
      b.di_valid = 1'b0;
      chk("t4_ovf", 32'({sticky2, ovf2, ecnt2, wcnt2}), 32'b1_1_11_11);
      clr2 = 1'b1;
      @(posedge clk);
      #1;
      clr2 = 1'b0;
      chk("t4_clr", 32'({sticky2, ovf2, ecnt2, wcnt2}), 32'd0);

      for (int i = 0; i < 2000; i++) begin
         a.di = 8'($urandom); a.pi = 1'($urandom);
         a.di_valid = $urandom_range(0, 3) != 0;
         a.do_ready = $urandom_range(0, 2) != 0;
         clr = $urandom_range(0, 63) == 0;
         cycle();
      end
      idle(3);

      a.do_ready = 1'b0; a.di_valid = 1'b1; a.di = 8'h33; a.pi = 1'b1;
      cycle(); cycle();
      chk("t6_full", 32'(a.di_ready), 32'd0);
      a.di_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("t6_do_valid", 32'(a.do_valid), 32'd0);
      chk("t6_di_ready", 32'(a.di_ready), 32'd1);
      chk("t6_stats", 32'({sticky, ovf, ecnt, wcnt}), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
